mem_model_axi_manager: RTL and testbench
========================================

Name: mem_model_axi_manager

Overview:
- AXI4 manager (initiator) that converts single-word memory-mapped commands into single-beat AXI4 write and read transactions.
- Bench-side counterpart of the AXI subordinate memory-model wrapper; drives it from a simple command port.
- Holds one transaction outstanding at a time.

Parameters:
ADDRWIDTH, 32, address width of command port and AXI addresses
DATAWIDTH, 32, data width; must be 32 or 64
ID_W_WIDTH, 4, width of awid/bid
ID_R_WIDTH, 4, width of arid/rid
TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
av_address  in  ADDRWIDTH  command address
av_write  in  1  write command
av_writedata  in  DATAWIDTH  write data
av_byteenable  in  DATAWIDTH/8  byte enables
av_read  in  1  read command
av_waitrequest  out  1  command stall
av_readdata  out  DATAWIDTH  read data
av_readdatavalid  out  1  read data strobe
awaddr/awvalid/awready/awburst/awsize/awlen/awid  out/out/in/out/out/out/out  ADDRWIDTH/1/1/2/3/8/ID_W_WIDTH  write address channel
wdata/wstrb/wvalid/wlast/wready  out/out/out/out/in  DATAWIDTH/DATAWIDTH/8/1/1/1  write data channel
bvalid/bready/bid  in/out/in  1/1/ID_W_WIDTH  write response channel
araddr/arvalid/arready/arburst/arsize/arlen/arid  out/out/in/out/out/out/out  ADDRWIDTH/1/1/2/3/8/ID_R_WIDTH  read address channel
rdata/rvalid/rready/rlast/rid  in/in/out/in/in  DATAWIDTH/1/1/1/ID_R_WIDTH  read data channel
timeout_err  out  1  sticky watchdog error

Behaviour:
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA.
- Reset: state IDLE. awvalid, wvalid, arvalid, bready, rready, av_readdatavalid and timeout_err are 0. ID counters are 0. av_readdata is 0.
- av_waitrequest = reset | (state != IDLE).
- Command acceptance: in IDLE a command is accepted when av_write or av_read is high. Address, data and byteenable are latched.
- Simultaneous av_write and av_read: the write is accepted; av_read is ignored for that cycle.
- WR_REQ: awvalid and wvalid rise in the cycle after acceptance. Each drops independently after its own handshake (valid & ready at a clock edge).
- WR_REQ exit: when both handshakes are done (same or different cycles), go to WR_RESP with bready=1.
- WR_RESP: bvalid & bready -> IDLE. The write ID counter then increments, wrapping modulo 2^ID_W_WIDTH.
- RD_REQ: arvalid=1. On arready -> RD_DATA with rready=1.
- RD_DATA: on rvalid, av_readdata <= rdata and av_readdatavalid pulses for exactly 1 cycle -> IDLE. The read ID counter increments, wrapping.
- Fixed AXI fields: awlen=arlen=0, awburst=arburst=2'b01 (INCR), awsize=arsize=log2(DATAWIDTH/8), wlast=wvalid.
- awaddr/araddr/wdata/wstrb hold stable while the corresponding valid is high.
- bid, rid and rlast are not checked.
- Minimum spacing with ready/valid always high: write accept to next accept is 3 cycles; read accept to readdatavalid is 3 cycles.
- Reset mid-transaction: immediate return to IDLE with all valids deasserted. The pending command is dropped and no readdatavalid is produced.

Optional Feature:
MEM_MODEL_AXI_MANAGER_TIMEOUT_EN
- Defined: a watchdog counter clears on each state change and increments in every non-IDLE state.
- On reaching TIMEOUT_CYCLES: timeout_err is set (sticky until reset), all valids/readies drop, FSM goes to IDLE.
- If the timeout occurs during a read, av_readdatavalid pulses with av_readdata = 0.
- Undefined: no counter; the FSM waits indefinitely; timeout_err is tied 0.

Decomposition:
- Package mem_model_axi_pkg holds:
  - FSM state enum
  - AXI_BURST_INCR = 2'b01
  - AXI_LEN_SINGLE = 8'h00
  - function for the size encoding from DATAWIDTH
- No sub-module; the block is a single FSM with registers.

Test Plan:
- Write 0x1000/0xCAFEF00D/0xF, subordinate ready always high -> one AW+W beat, awid=0, wstrb=0xF, waitrequest low again 3 cycles after accept.
- Read 0x1000 after the write -> arid=0, av_readdata=0xCAFEF00D with a single-cycle readdatavalid.
- wready held low 5 cycles, awready immediate -> awvalid drops after 1 cycle, wvalid held with stable data until wready, then exactly one B handshake.
- 17 consecutive writes with ID_W_WIDTH=4 -> awid sequence 0..15,0.
- Reset asserted while in RD_DATA -> next cycle all valids/readies 0, no readdatavalid, waitrequest low after reset release.
- With the macro, TIMEOUT_CYCLES=16, bvalid never asserted -> timeout_err=1 after 16 cycles in WR_RESP, FSM IDLE.

Source files
------------

// File: rtl/mem_model_axi_pkg.sv
// Shared types and constants for the single-beat AXI4 manager that drives the memory-model subordinate.
package mem_model_axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'h00;

  // AXI size encoding is log2 of the bytes per beat.
  function automatic logic [2:0] axi_size(input int data_width);
    logic [2:0] sz;
    sz = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((8 << i) == data_width) sz = 3'(i);
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_model_axi_manager.sv
// AXI4 manager turning single-word commands into single-beat AXI writes/reads, one outstanding at a time.
// Optional watchdog enabled by defining MEM_MODEL_AXI_MANAGER_TIMEOUT_EN.
module mem_model_axi_manager
  import mem_model_axi_pkg::*;
#(
  parameter int ADDRWIDTH      = 32,
  parameter int DATAWIDTH      = 32,
  parameter int ID_W_WIDTH     = 4,
  parameter int ID_R_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDRWIDTH-1:0]    av_address,
  input  logic                    av_write,
  input  logic [DATAWIDTH-1:0]    av_writedata,
  input  logic [DATAWIDTH/8-1:0]  av_byteenable,
  input  logic                    av_read,
  output logic                    av_waitrequest,
  output logic [DATAWIDTH-1:0]    av_readdata,
  output logic                    av_readdatavalid,
  output logic [ADDRWIDTH-1:0]    awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [1:0]              awburst,
  output logic [2:0]              awsize,
  output logic [7:0]              awlen,
  output logic [ID_W_WIDTH-1:0]   awid,
  output logic [DATAWIDTH-1:0]    wdata,
  output logic [DATAWIDTH/8-1:0]  wstrb,
  output logic                    wvalid,
  output logic                    wlast,
  input  logic                    wready,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [ID_W_WIDTH-1:0]   bid,
  output logic [ADDRWIDTH-1:0]    araddr,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [1:0]              arburst,
  output logic [2:0]              arsize,
  output logic [7:0]              arlen,
  output logic [ID_R_WIDTH-1:0]   arid,
  input  logic [DATAWIDTH-1:0]    rdata,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic                    rlast,
  input  logic [ID_R_WIDTH-1:0]   rid,
  output logic                    timeout_err
);

  if (DATAWIDTH != 32 && DATAWIDTH != 64) begin : g_bad_datawidth
    $error("mem_model_axi_manager: DATAWIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_model_axi_manager: TIMEOUT_CYCLES must be at least 1");
  end

  localparam logic [2:0] AXI_SIZE = axi_size(DATAWIDTH);

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDRWIDTH-1:0]    addr_q;
  logic [DATAWIDTH-1:0]    wdata_q;
  logic [DATAWIDTH/8-1:0]  strb_q;
  logic                    aw_done;
  logic                    w_done;
  logic [ID_W_WIDTH-1:0]   wr_id;
  logic [ID_R_WIDTH-1:0]   rd_id;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    b_hs;
  logic                    ar_hs;
  logic                    r_hs;
  logic                    accept;
  logic                    wd_expired;
  logic                    timeout_fire;

  // Response IDs and rlast are deliberately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{bid, rid, rlast};

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign b_hs   = bvalid & bready;
  assign ar_hs  = arvalid & arready;
  assign r_hs   = rvalid & rready;
  assign accept = (state == IDLE) & (av_write | av_read);

`ifdef MEM_MODEL_AXI_MANAGER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  assign wd_expired  = (state != IDLE) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_q;

  // Watchdog measures time spent in the current non-idle state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_nxt != state) begin
        wd_cnt <= '0;
      end else if (state != IDLE) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (timeout_fire) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    timeout_fire = 1'b0;
    case (state)
      IDLE: begin
        if (av_write)     state_nxt = WR_REQ;
        else if (av_read) state_nxt = RD_REQ;
      end
      WR_REQ: begin
        if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) state_nxt = IDLE;
      end
      RD_REQ: begin
        if (ar_hs) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        if (r_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A transaction finishing in the expiry cycle wins over the watchdog.
    if (wd_expired && (state_nxt == state)) begin
      timeout_fire = 1'b1;
      state_nxt    = IDLE;
    end
  end

  always_comb begin
    av_waitrequest = reset | (state != IDLE);
    awvalid        = (state == WR_REQ) & ~aw_done;
    wvalid         = (state == WR_REQ) & ~w_done;
    bready         = (state == WR_RESP);
    arvalid        = (state == RD_REQ);
    rready         = (state == RD_DATA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q           <= '0;
      wdata_q          <= '0;
      strb_q           <= '0;
      aw_done          <= 1'b0;
      w_done           <= 1'b0;
      wr_id            <= '0;
      rd_id            <= '0;
      av_readdata      <= '0;
      av_readdatavalid <= 1'b0;
    end else begin
      av_readdatavalid <= 1'b0;
      if (accept) begin
        addr_q  <= av_address;
        wdata_q <= av_writedata;
        strb_q  <= av_byteenable;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (b_hs)  wr_id   <= wr_id + ID_W_WIDTH'(1);
      if (r_hs) begin
        av_readdata      <= rdata;
        av_readdatavalid <= 1'b1;
        rd_id            <= rd_id + ID_R_WIDTH'(1);
      end else if (timeout_fire && (state == RD_REQ || state == RD_DATA)) begin
        // An abandoned read still completes towards the command side, with zero data.
        av_readdata      <= '0;
        av_readdatavalid <= 1'b1;
      end
    end
  end

  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign wdata   = wdata_q;
  assign wstrb   = strb_q;
  assign wlast   = wvalid;
  assign awid    = wr_id;
  assign arid    = rd_id;
  assign awlen   = AXI_LEN_SINGLE;
  assign arlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign arburst = AXI_BURST_INCR;
  assign awsize  = AXI_SIZE;
  assign arsize  = AXI_SIZE;

endmodule

// File: tb/tb_mem_model_axi_manager.sv
// Directed testbench for mem_model_axi_manager with a small AXI subordinate memory model.
// Watchdog scenario is compiled in when MEM_MODEL_AXI_MANAGER_TIMEOUT_EN is defined.
module tb_mem_model_axi_manager;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IDW = 4;
  localparam int IDR = 4;
  localparam int TO  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   av_address;
  logic            av_write;
  logic [DW-1:0]   av_writedata;
  logic [DW/8-1:0] av_byteenable;
  logic            av_read;
  logic            av_waitrequest;
  logic [DW-1:0]   av_readdata;
  logic            av_readdatavalid;
  logic [AW-1:0]   awaddr;
  logic            awvalid;
  logic            awready;
  logic [1:0]      awburst;
  logic [2:0]      awsize;
  logic [7:0]      awlen;
  logic [IDW-1:0]  awid;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wlast;
  logic            wready;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic            arvalid;
  logic            arready;
  logic [1:0]      arburst;
  logic [2:0]      arsize;
  logic [7:0]      arlen;
  logic [IDR-1:0]  arid;
  logic [DW-1:0]   rdata;
  logic            rvalid;
  logic            rready;
  logic            timeout_err;

  logic            bvalid_en;
  logic            rvalid_en;
  logic [DW-1:0]   rdata_q;
  logic [AW-1:0]   aw_addr_q;
  logic [DW-1:0]   w_data_q;
  logic [DW/8-1:0] w_strb_q;
  logic [DW-1:0]   mem [64];

  int aw_cnt = 0;
  int w_cnt = 0;
  int b_cnt = 0;
  int ar_cnt = 0;
  int rdv_cnt = 0;
  logic [IDW-1:0] awid_log [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign bvalid = bvalid_en;
  assign rvalid = rvalid_en;
  assign rdata  = rdata_q;

  mem_model_axi_manager #(
    .ADDRWIDTH(AW), .DATAWIDTH(DW), .ID_W_WIDTH(IDW), .ID_R_WIDTH(IDR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .av_address(av_address), .av_write(av_write), .av_writedata(av_writedata),
    .av_byteenable(av_byteenable), .av_read(av_read), .av_waitrequest(av_waitrequest),
    .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awburst(awburst),
    .awsize(awsize), .awlen(awlen), .awid(awid),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .bvalid(bvalid), .bready(bready), .bid('0),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arburst(arburst),
    .arsize(arsize), .arlen(arlen), .arid(arid),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(1'b1), .rid('0),
    .timeout_err(timeout_err)
  );

  function automatic logic [5:0] widx(input logic [AW-1:0] a);
    return {a[13:12], a[5:2]};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [DW/8-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < DW/8; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // Subordinate memory: commits a write on the B handshake, fetches read data on AR.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      rdata_q   <= '0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (awvalid && awready) aw_addr_q <= awaddr;
      if (wvalid && wready) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (bvalid && bready) mem[widx(aw_addr_q)] <= merge(mem[widx(aw_addr_q)], w_data_q, w_strb_q);
      if (arvalid && arready) rdata_q <= mem[widx(araddr)];
    end
  end

  always @(posedge clk) begin
    if (awvalid && awready) begin
      aw_cnt <= aw_cnt + 1;
      awid_log.push_back(awid);
    end
    if (wvalid && wready) w_cnt <= w_cnt + 1;
    if (bvalid && bready) b_cnt <= b_cnt + 1;
    if (arvalid && arready) ar_cnt <= ar_cnt + 1;
    if (av_readdatavalid) rdv_cnt <= rdv_cnt + 1;
  end

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [DW/8-1:0] be);
    av_write      = wr;
    av_read       = rd;
    av_address    = a;
    av_writedata  = d;
    av_byteenable = be;
    @(negedge clk);
    av_write = 1'b0;
    av_read  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (av_waitrequest && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    av_write = 0; av_read = 0; av_address = '0; av_writedata = '0; av_byteenable = '0;
    awready = 1; wready = 1; arready = 1; bvalid_en = 1; rvalid_en = 1;
    reset = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (av_waitrequest !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_waitrequest: got %b expected 1", av_waitrequest);
    end
    reset = 0;
    @(negedge clk);
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, av_readdatavalid, timeout_err, av_waitrequest} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000000",
               {awvalid, wvalid, arvalid, bready, rready, av_readdatavalid, timeout_err, av_waitrequest});
    end
    checks++;
    if ({av_readdata, awid, arid} !== '0) begin
      errors++; $display("[TB] FAIL reset_data_ids: got %h/%h/%h expected 0", av_readdata, awid, arid);
    end
  endtask

  task automatic test_write();
    int a0, w0, b0, n;
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    applyStimulus(1, 0, 32'h1000, 32'hCAFEF00D, 4'hF);
    checks++;
    if ({av_waitrequest, awvalid, wvalid, wlast} !== 4'b1111) begin
      errors++; $display("[TB] FAIL wr_valids: got %b expected 1111", {av_waitrequest, awvalid, wvalid, wlast});
    end
    checks++;
    if ({awaddr, wdata, wstrb, awid} !== {32'h1000, 32'hCAFEF00D, 4'hF, 4'h0}) begin
      errors++; $display("[TB] FAIL wr_fields: got %h %h %h %h expected 1000 cafef00d f 0", awaddr, wdata, wstrb, awid);
    end
    checks++;
    if ({awlen, awburst, awsize} !== {8'h00, 2'b01, 3'd2}) begin
      errors++; $display("[TB] FAIL wr_fixed: got %h %b %0d expected 00 01 2", awlen, awburst, awsize);
    end
    wait_idle(10, n);
    checks++;
    if (n !== 2) begin
      errors++; $display("[TB] FAIL wr_spacing: got %0d expected 2 cycles to idle", n);
    end
    checks++;
    if ({aw_cnt - a0, w_cnt - w0, b_cnt - b0} !== {32'd1, 32'd1, 32'd1}) begin
      errors++; $display("[TB] FAIL wr_handshakes: got %0d %0d %0d expected 1 1 1", aw_cnt - a0, w_cnt - w0, b_cnt - b0);
    end
  endtask

  task automatic test_read();
    int r0;
    r0 = rdv_cnt;
    applyStimulus(0, 1, 32'h1000, '0, '0);
    checks++;
    if ({arvalid, araddr, arid, arlen, arburst, arsize} !== {1'b1, 32'h1000, 4'h0, 8'h00, 2'b01, 3'd2}) begin
      errors++; $display("[TB] FAIL rd_request: got %b %h %h %h %b %0d expected 1 1000 0 00 01 2",
                         arvalid, araddr, arid, arlen, arburst, arsize);
    end
    @(negedge clk);
    checks++;
    if ({arvalid, rready, av_readdatavalid} !== 3'b010) begin
      errors++; $display("[TB] FAIL rd_data_phase: got %b expected 010", {arvalid, rready, av_readdatavalid});
    end
    @(negedge clk);
    checks++;
    if ({av_readdatavalid, av_waitrequest, av_readdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      errors++; $display("[TB] FAIL rd_result: got %b %b %h expected 1 0 cafef00d",
                         av_readdatavalid, av_waitrequest, av_readdata);
    end
    @(negedge clk);
    checks++;
    if (av_readdatavalid !== 1'b0 || rdv_cnt - r0 !== 1) begin
      errors++; $display("[TB] FAIL rd_pulse: got valid %b count %0d expected 0 1", av_readdatavalid, rdv_cnt - r0);
    end
  endtask

  task automatic test_wready_stall();
    int a0, w0, b0, bad;
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; bad = 0;
    wready = 0;
    applyStimulus(1, 0, 32'h2000, 32'h12345678, 4'h3);
    checks++;
    if ({awvalid, wvalid} !== 2'b11) begin
      errors++; $display("[TB] FAIL stall_start: got %b expected 11", {awvalid, wvalid});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if ({awvalid, wvalid, wdata, wstrb} !== {1'b0, 1'b1, 32'h12345678, 4'h3}) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("[TB] FAIL stall_hold: got %0d bad cycles expected 0", bad);
    end
    wready = 1;
    @(negedge clk);
    checks++;
    if ({wvalid, bready} !== 2'b01) begin
      errors++; $display("[TB] FAIL stall_resp: got %b expected 01", {wvalid, bready});
    end
    @(negedge clk);
    checks++;
    if ({av_waitrequest, aw_cnt - a0, w_cnt - w0, b_cnt - b0} !== {1'b0, 32'd1, 32'd1, 32'd1}) begin
      errors++; $display("[TB] FAIL stall_done: got %b %0d %0d %0d expected 0 1 1 1",
                         av_waitrequest, aw_cnt - a0, w_cnt - w0, b_cnt - b0);
    end
    applyStimulus(0, 1, 32'h2000, '0, '0);
    checks++;
    if (arid !== 4'h1) begin
      errors++; $display("[TB] FAIL stall_arid: got %h expected 1", arid);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({av_readdatavalid, av_readdata} !== {1'b1, 32'h00005678}) begin
      errors++; $display("[TB] FAIL stall_readback: got %b %h expected 1 00005678", av_readdatavalid, av_readdata);
    end
  endtask

  task automatic test_simultaneous();
    int a0, r0, n;
    a0 = aw_cnt; r0 = ar_cnt;
    applyStimulus(1, 1, 32'h3000, 32'hA5A5A5A5, 4'hF);
    checks++;
    if ({awvalid, arvalid} !== 2'b10) begin
      errors++; $display("[TB] FAIL simul_priority: got %b expected 10", {awvalid, arvalid});
    end
    wait_idle(10, n);
    @(negedge clk);
    checks++;
    if ({aw_cnt - a0, ar_cnt - r0} !== {32'd1, 32'd0}) begin
      errors++; $display("[TB] FAIL simul_counts: got %0d %0d expected 1 0", aw_cnt - a0, ar_cnt - r0);
    end
    applyStimulus(0, 1, 32'h3000, '0, '0);
    repeat (2) @(negedge clk);
    checks++;
    if ({av_readdatavalid, av_readdata} !== {1'b1, 32'hA5A5A5A5}) begin
      errors++; $display("[TB] FAIL simul_readback: got %b %h expected 1 a5a5a5a5", av_readdatavalid, av_readdata);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int s, n, stuck;
    stuck = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    s = awid_log.size();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 0, AW'(i * 4), DW'(i), 4'hF);
      wait_idle(10, n);
      if (n !== 2) stuck++;
    end
    checks++;
    if (stuck !== 0 || awid_log.size() - s !== 17) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d slow, %0d writes expected 0, 17", stuck, awid_log.size() - s);
    end
    for (int i = 0; i < 17 && s + i < awid_log.size(); i++) begin
      checks++;
      if (awid_log[s + i] !== IDW'(i % 16)) begin
        errors++; $display("[TB] FAIL b2b_awid[%0d]: got %h expected %h", i, awid_log[s + i], i % 16);
      end
    end
  endtask

  task automatic test_reset_rd_data();
    int r0;
    rvalid_en = 0;
    r0 = rdv_cnt;
    applyStimulus(0, 1, 32'h0004, '0, '0);
    @(negedge clk);
    checks++;
    if (rready !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_rd_pre: got rready %b expected 1", rready);
    end
    reset = 1;
    @(negedge clk);
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, av_readdatavalid, av_waitrequest} !== 7'b0000001) begin
      errors++; $display("[TB] FAIL rst_rd_drop: got %b expected 0000001",
                         {awvalid, wvalid, arvalid, bready, rready, av_readdatavalid, av_waitrequest});
    end
    reset = 0;
    rvalid_en = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (av_waitrequest !== 1'b0 || rdv_cnt !== r0) begin
      errors++; $display("[TB] FAIL rst_rd_after: got wait %b rdv %0d expected 0 %0d", av_waitrequest, rdv_cnt, r0);
    end
    applyStimulus(0, 1, 32'h0004, '0, '0);
    checks++;
    if (arid !== 4'h0) begin
      errors++; $display("[TB] FAIL rst_rd_arid: got %h expected 0", arid);
    end
    repeat (3) @(negedge clk);
  endtask

`ifdef MEM_MODEL_AXI_MANAGER_TIMEOUT_EN
  task automatic test_timeout();
    bvalid_en = 0;
    applyStimulus(1, 0, 32'h0010, 32'h1, 4'hF);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 16) begin
        checks++;
        if ({bready, timeout_err} !== 2'b10) begin
          errors++; $display("[TB] FAIL to_before: got %b expected 10", {bready, timeout_err});
        end
      end
      if (k == 17) begin
        checks++;
        if ({bready, timeout_err, av_waitrequest} !== 3'b010) begin
          errors++; $display("[TB] FAIL to_fire: got %b expected 010", {bready, timeout_err, av_waitrequest});
        end
      end
    end
    bvalid_en = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("[TB] FAIL to_sticky: got %b expected 1", timeout_err);
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("[TB] FAIL to_clear: got %b expected 0", timeout_err);
    end
  endtask
`else
  task automatic test_timeout();
    int n;
    bvalid_en = 0;
    applyStimulus(1, 0, 32'h0010, 32'h1, 4'hF);
    repeat (40) @(negedge clk);
    checks++;
    if ({bready, timeout_err, av_waitrequest} !== 3'b101) begin
      errors++; $display("[TB] FAIL no_to_wait: got %b expected 101", {bready, timeout_err, av_waitrequest});
    end
    bvalid_en = 1;
    wait_idle(10, n);
    checks++;
    if (av_waitrequest !== 1'b0) begin
      errors++; $display("[TB] FAIL no_to_finish: got %b expected 0", av_waitrequest);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wready_stall();
    test_simultaneous();
    test_back_to_back();
    test_reset_rd_data();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] aborted");
  end

endmodule
